// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchronised and filtered clock sampling, 11-bit frame checks,
// inter-bit timeout, E0/F0 prefix decode and a show-ahead event FIFO with valid/ready output.

package ps2_key_event_pkg;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

endpackage

module ps2_key_event_rx
    import ps2_key_event_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned FIFO_AW        = 4
) (
    input  logic               CLOCK_50,
    input  logic               Resetn,
    input  logic               PS2_CLK,
    input  logic               PS2_DAT,
    input  logic               ev_ready,
    input  logic               clear_err,
    output logic               ev_valid,
    output logic [7:0]         ev_code,
    output logic               ev_ext,
    output logic               ev_break,
    output logic [FIFO_AW:0]   ev_count,
    output logic               err_parity,
    output logic               err_frame,
    output logic               overflow
);

    localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W  = FIFO_AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers (idle-high lines reset to 1)
    // ------------------------------------------------------------------
    logic clk_s1, clk_s2, dat_s1, dat_s2;

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2_CLK;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2_DAT;
            dat_s2 <= dat_s1;
        end
    end

    // ------------------------------------------------------------------
    // Clock glitch filter; the falling transition yields a one-cycle strobe
    // ------------------------------------------------------------------
    logic              clk_filt;
    logic [FILT_W-1:0] filt_cnt;
    logic              strobe;
    logic              strobe_dat;

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            clk_filt   <= 1'b1;
            filt_cnt   <= '0;
            strobe     <= 1'b0;
            strobe_dat <= 1'b1;
        end else begin
            strobe <= 1'b0;
            if (clk_s2 != clk_filt) begin
                if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
                    clk_filt   <= clk_s2;
                    filt_cnt   <= '0;
                    strobe     <= ~clk_s2;
                    strobe_dat <= dat_s2;
                end else begin
                    filt_cnt <= filt_cnt + FILT_W'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: state register
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        par_q, par_d;
    logic        byte_vld_q, byte_vld_d;
    logic        drop_q, drop_d;
    logic        set_perr_c, set_ferr_c;
    logic        abort_c;
    logic        par_ok_c;
    logic [TMO_W-1:0] tmo_q;

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            byte_vld_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            byte_vld_q <= byte_vld_d;
            drop_q     <= drop_d;
        end
    end

    // Inter-bit timeout, only armed while a frame is in progress
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn || strobe || state_q == S_IDLE) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    assign abort_c  = (state_q != S_IDLE) && !strobe && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign par_ok_c = ^{shreg_q, par_q};

    // ------------------------------------------------------------------
    // Frame FSM: next state and frame-check outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        par_d      = par_q;
        byte_vld_d = 1'b0;
        drop_d     = 1'b0;
        set_perr_c = 1'b0;
        set_ferr_c = 1'b0;

        if (abort_c) begin
            state_d    = S_IDLE;
            set_ferr_c = 1'b1;
            drop_d     = 1'b1;
        end else if (strobe) begin
            case (state_q)
                S_IDLE: begin
                    if (!strobe_dat) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        set_ferr_c = 1'b1;
                    end
                end
                S_DATA: begin
                    shreg_d   = {strobe_dat, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = strobe_dat;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d    = S_IDLE;
                    set_perr_c = ~par_ok_c;
                    set_ferr_c = ~strobe_dat;
                    if (!par_ok_c || !strobe_dat) begin
                        drop_d = 1'b1;
                    end else begin
                        byte_vld_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder: E0/F0 only arm flags; any other byte becomes an event
    // ------------------------------------------------------------------
    logic       ext_q, brk_q;
    logic       is_e0_c, is_f0_c, push_c;
    ps2_event_t push_data_c;

    assign is_e0_c     = (shreg_q == 8'hE0);
    assign is_f0_c     = (shreg_q == 8'hF0);
    assign push_c      = byte_vld_q && !is_e0_c && !is_f0_c;
    assign push_data_c = '{ext: ext_q, brk: brk_q, code: shreg_q};

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (drop_q || push_c) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (byte_vld_q) begin
            if (is_e0_c) ext_q <= 1'b1;
            if (is_f0_c) brk_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead event FIFO with registered head outputs
    // ------------------------------------------------------------------
    ps2_event_t         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_d;
    logic               full_c, pop_c, wr_en_c, ovf_set_c;
    ps2_event_t         head_d;

    assign full_c    = (ev_count == CNT_W'(FIFO_DEPTH));
    assign pop_c     = (ev_count != '0) && ev_ready;
    assign wr_en_c   = push_c && (!full_c || pop_c);
    assign ovf_set_c = push_c && full_c && !pop_c;

    always_comb begin
        count_d  = ev_count;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_c && !pop_c) count_d = ev_count + CNT_W'(1);
        if (!wr_en_c && pop_c) count_d = ev_count - CNT_W'(1);
        if (pop_c) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        // A write landing on the new head slot bypasses the array
        if (wr_en_c && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data_c;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= push_data_c;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ev_count <= '0;
            ev_valid <= 1'b0;
            ev_code  <= '0;
            ev_ext   <= 1'b0;
            ev_break <= 1'b0;
        end else begin
            if (wr_en_c) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            rd_ptr_q <= rd_ptr_d;
            ev_count <= count_d;
            ev_valid <= (count_d != '0);
            ev_code  <= head_d.code;
            ev_ext   <= head_d.ext;
            ev_break <= head_d.brk;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags; a set wins over a same-cycle clear
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            err_parity <= set_perr_c | (err_parity & ~clear_err);
            err_frame  <= set_ferr_c | (err_frame & ~clear_err);
            overflow   <= ovf_set_c  | (overflow & ~clear_err);
        end
    end

endmodule
